// File: rtl/pipe_hazard_regs_if.sv
// Pipeline register bundle: decode-stage inputs, hazard controls and the
// registered E/M/W views plus event counters.
interface pipe_hazard_regs_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      InstrF;
   logic [3:0]       RA1D, RA2D, WA3D;
   logic             RegWriteD, MemtoRegD, MemWriteD;
   logic             StallD, FlushD, FlushE;

   logic [31:0]      InstrD;
   logic [3:0]       RA1E, RA2E, WA3E;
   logic             RegWriteE, MemtoRegE, MemWriteE, ValidE;
   logic [3:0]       WA3M;
   logic             RegWriteM, MemtoRegM, MemWriteM, ValidM;
   logic [3:0]       WA3W;
   logic             RegWriteW, MemtoRegW, ValidW;
   logic [CNT_W-1:0] StallCnt, FlushCnt;
   logic [31:0]      RetireCnt;

   modport master (
      output InstrF, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, MemWriteD,
             StallD, FlushD, FlushE,
      input  InstrD, RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MemWriteE, ValidE,
             WA3M, RegWriteM, MemtoRegM, MemWriteM, ValidM,
             WA3W, RegWriteW, MemtoRegW, ValidW,
             StallCnt, FlushCnt, RetireCnt
   );

   modport slave (
      input  InstrF, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, MemWriteD,
             StallD, FlushD, FlushE,
      output InstrD, RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MemWriteE, ValidE,
             WA3M, RegWriteM, MemtoRegM, MemWriteM, ValidM,
             WA3W, RegWriteW, MemtoRegW, ValidW,
             StallCnt, FlushCnt, RetireCnt
   );
endinterface

// File: rtl/pipe_hazard_regs.sv
// F/D, D/E, E/M and M/W pipeline registers with stall/flush handling and
// saturating stall/flush counters plus a wrapping retire counter.
module pipe_hazard_regs #(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_regs_if.slave bus
);

   typedef struct packed {
      logic [3:0] ra1;
      logic [3:0] ra2;
      logic [3:0] wa3;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       valid;
   } de_t;

   typedef struct packed {
      logic [3:0] wa3;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       valid;
   } em_t;

   typedef struct packed {
      logic [3:0] wa3;
      logic       reg_write;
      logic       mem_to_reg;
      logic       valid;
   } mw_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      instr_d_q, instr_d_d;
   logic             valid_d_q, valid_d_d;
   de_t              de_q, de_d;
   em_t              em_q, em_d;
   mw_t              mw_q, mw_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [31:0]      retire_cnt_q, retire_cnt_d;

   // FlushD wins over StallD so a squashed slot never lingers as a held one.
   always_comb begin
      // NOTE: every combinational output gets a default first; a missing branch would otherwise infer a latch.
      instr_d_d = instr_d_q;
      valid_d_d = valid_d_q;
      if (bus.FlushD) begin
         instr_d_d = '0;
         valid_d_d = 1'b0;
      end else if (!bus.StallD) begin
         instr_d_d = bus.InstrF;
         valid_d_d = 1'b1;
      end
   end

   always_comb begin
      de_d = '0;
      if (!bus.FlushE) begin
         de_d.ra1        = bus.RA1D;
         de_d.ra2        = bus.RA2D;
         de_d.wa3        = bus.WA3D;
         de_d.reg_write  = bus.RegWriteD;
         de_d.mem_to_reg = bus.MemtoRegD;
         de_d.mem_write  = bus.MemWriteD;
         de_d.valid      = valid_d_q;
      end
   end

   always_comb begin
      em_d = '{wa3: de_q.wa3, reg_write: de_q.reg_write, mem_to_reg: de_q.mem_to_reg,
               mem_write: de_q.mem_write, valid: de_q.valid};
      mw_d = '{wa3: em_q.wa3, reg_write: em_q.reg_write, mem_to_reg: em_q.mem_to_reg,
               valid: em_q.valid};
   end

   // A cycle with both flushes is one flush event.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (bus.StallD && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if ((bus.FlushD || bus.FlushE) && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
      retire_cnt_d = retire_cnt_q + {31'd0, mw_q.valid};
   end

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
      if (rst) begin
         instr_d_q    <= '0;
         valid_d_q    <= 1'b0;
         de_q         <= '0;
         em_q         <= '0;
         mw_q         <= '0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         instr_d_q    <= instr_d_d;
         valid_d_q    <= valid_d_d;
         de_q         <= de_d;
         em_q         <= em_d;
         mw_q         <= mw_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign bus.InstrD    = instr_d_q;
   assign bus.RA1E      = de_q.ra1;
   assign bus.RA2E      = de_q.ra2;
   assign bus.WA3E      = de_q.wa3;
   assign bus.RegWriteE = de_q.reg_write;
   assign bus.MemtoRegE = de_q.mem_to_reg;
   assign bus.MemWriteE = de_q.mem_write;
   assign bus.ValidE    = de_q.valid;
   assign bus.WA3M      = em_q.wa3;
   assign bus.RegWriteM = em_q.reg_write;
   assign bus.MemtoRegM = em_q.mem_to_reg;
   assign bus.MemWriteM = em_q.mem_write;
   assign bus.ValidM    = em_q.valid;
   assign bus.WA3W      = mw_q.wa3;
   assign bus.RegWriteW = mw_q.reg_write;
   assign bus.MemtoRegW = mw_q.mem_to_reg;
   assign bus.ValidW    = mw_q.valid;
   assign bus.StallCnt  = stall_cnt_q;
   assign bus.FlushCnt  = flush_cnt_q;
   assign bus.RetireCnt = retire_cnt_q;

endmodule
